// File: rtl/calc_key_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator key sequencer and the ALU it drives:
//   - keypad code constants (equals, clear, operator base)
//   - sequencer state encoding
//   - ALU select map (shared with the ALU so both sides agree)
//   - key classification helpers
// -----------------------------------------------------------------------------
package calc_pkg;

  localparam logic [4:0] KEY_EQ      = 5'h18;
  localparam logic [4:0] KEY_CLR     = 5'h19;
  localparam logic [4:0] KEY_OP_BASE = 5'h10;

  localparam logic [2:0] SEL_ADD = 3'b000;
  localparam logic [2:0] SEL_SUB = 3'b001;
  localparam logic [2:0] SEL_AND = 3'b010;
  localparam logic [2:0] SEL_OR  = 3'b011;
  localparam logic [2:0] SEL_XOR = 3'b100;
  localparam logic [2:0] SEL_NOT = 3'b101;
  localparam logic [2:0] SEL_SHL = 3'b110;
  localparam logic [2:0] SEL_SHR = 3'b111;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_EXEC = 2'd2,
    S_SHOW = 2'd3
  } state_t;

  // Codes 0x00..0x09 are decimal digits; 0x0A..0x0F are ignored.
  function automatic logic is_digit(input logic [4:0] code);
    return (code[4] == 1'b0) && (code[3:0] <= 4'd9);
  endfunction

  // Codes 0x10..0x17 are operators; the low three bits are the ALU select.
  function automatic logic is_op(input logic [4:0] code);
    return (code[4:3] == 2'b10);
  endfunction

endpackage

// File: rtl/calc_key_sequencer_if.sv
// -----------------------------------------------------------------------------
// calc_key_sequencer_if
// Bundles the keypad handshake, the ALU operand/result bus and the display
// outputs of the calculator key sequencer.
//   master : the sequencer (consumes keys, drives ALU inputs and display)
//   slave  : the environment (keypad source, ALU, display sink)
// Signals:
//   key_valid/key_code/key_ready : keypad stream, accepted on valid && ready
//   alu_a/alu_b/alu_sel          : ALU operands and select
//   alu_y                        : ALU result
//   display/result_valid/entry_ovf : display value, capture pulse, sticky ovf
// -----------------------------------------------------------------------------
interface calc_key_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             key_valid;
  logic [4:0]       key_code;
  logic             key_ready;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] display;
  logic             result_valid;
  logic             entry_ovf;

  modport master (
    input  key_valid, key_code, alu_y,
    output key_ready, alu_a, alu_b, alu_sel, display, result_valid, entry_ovf
  );

  modport slave (
    output key_valid, key_code, alu_y,
    input  key_ready, alu_a, alu_b, alu_sel, display, result_valid, entry_ovf
  );
endinterface

// File: rtl/calc_key_sequencer_digit_acc.sv
// -----------------------------------------------------------------------------
// calc_digit_acc
// Combinational decimal entry step: o_sum = i_acc*10 + i_digit, evaluated at
// WIDTH+4 bits so the true value is never lost. o_ovf flags that the result
// does not fit in WIDTH bits, in which case the caller keeps its old value.
// Ports:
//   i_acc   : current entry value
//   i_digit : digit 0..9
//   o_sum   : low WIDTH bits of i_acc*10 + i_digit
//   o_ovf   : 1 when i_acc*10 + i_digit > 2^WIDTH-1
// -----------------------------------------------------------------------------
module calc_digit_acc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic [3:0]       i_digit,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_ovf
);
  logic [WIDTH+3:0] w_x;
  logic [WIDTH+3:0] w_wide;

  // x*10 = x*8 + x*2; the extra 4 bits hold up to 10*2^WIDTH - 1.
  always_comb begin
    w_x    = {4'b0000, i_acc};
    w_wide = (w_x << 3) + (w_x << 1) + {{WIDTH{1'b0}}, i_digit};
    o_sum  = w_wide[WIDTH-1:0];
    o_ovf  = |w_wide[WIDTH+3:WIDTH];
  end
endmodule

// File: rtl/calc_key_sequencer.sv
// -----------------------------------------------------------------------------
// calc_key_sequencer
// Calculator front-end for a combinational 8-bit ALU. Builds decimal operands
// A and B from a keypad stream, drives the ALU, waits ALU_WAIT cycles, captures
// the result and shows it. Supports chained operators and repeat-equals.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : calc_key_sequencer_if.master (keys, ALU bus, display outputs)
// Parameters:
//   WIDTH    : operand/result width, must match the ALU
//   ALU_WAIT : cycles the ALU inputs are held before y is sampled (>= 1)
// -----------------------------------------------------------------------------
module calc_key_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int ALU_WAIT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  calc_key_sequencer_if.master bus
);
  localparam int CNT_W = (ALU_WAIT > 1) ? $clog2(ALU_WAIT) : 1;

  state_t           r_state,    w_state_nxt;
  logic [WIDTH-1:0] r_a,        w_a_nxt;
  logic [WIDTH-1:0] r_b,        w_b_nxt;
  logic [WIDTH-1:0] r_last_b,   w_last_b_nxt;
  logic [WIDTH-1:0] r_alu_a,    w_alu_a_nxt;
  logic [WIDTH-1:0] r_alu_b,    w_alu_b_nxt;
  logic [WIDTH-1:0] r_disp_hold, w_disp_hold_nxt;
  logic [2:0]       r_sel,      w_sel_nxt;
  logic [2:0]       r_pend_sel, w_pend_sel_nxt;
  logic [2:0]       r_alu_sel,  w_alu_sel_nxt;
  logic             r_chain,    w_chain_nxt;
  logic             r_b_ent,    w_b_ent_nxt;
  logic             r_ovf,      w_ovf_nxt;
  logic             r_rv,       w_rv_nxt;
  logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;

  logic             w_key_ready;
  logic             w_accept;
  logic             w_is_digit;
  logic             w_is_op;
  logic             w_is_eq;
  logic             w_is_clr;
  logic [3:0]       w_digit;
  logic [WIDTH-1:0] w_acc_in;
  logic [WIDTH-1:0] w_acc_sum;
  logic             w_acc_ovf;
  logic [WIDTH-1:0] w_display;
  logic             w_enter_exec;
  logic [WIDTH-1:0] w_exec_b;

  assign w_key_ready = (r_state != S_EXEC);
  assign w_accept    = bus.key_valid && w_key_ready;
  assign w_is_digit  = is_digit(bus.key_code);
  assign w_is_op     = is_op(bus.key_code);
  assign w_is_eq     = (bus.key_code == KEY_EQ);
  assign w_is_clr    = (bus.key_code == KEY_CLR);
  assign w_digit     = bus.key_code[3:0];

  // One accumulator serves both operands; B is only ever entered in S_B.
  assign w_acc_in = (r_state == S_B) ? r_b : r_a;

  calc_digit_acc #(.WIDTH(WIDTH)) u_digit_acc (
    .i_acc   (w_acc_in),
    .i_digit (w_digit),
    .o_sum   (w_acc_sum),
    .o_ovf   (w_acc_ovf)
  );

  // A holds R after a capture, so S_SHOW shows A.
  always_comb begin
    w_display = r_a;
    case (r_state)
      S_A:     w_display = r_a;
      S_B:     w_display = r_b_ent ? r_b : r_a;
      S_EXEC:  w_display = r_disp_hold;
      S_SHOW:  w_display = r_a;
      default: w_display = r_a;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_A;
      r_a         <= '0;
      r_b         <= '0;
      r_last_b    <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_disp_hold <= '0;
      r_sel       <= '0;
      r_pend_sel  <= '0;
      r_alu_sel   <= '0;
      r_chain     <= 1'b0;
      r_b_ent     <= 1'b0;
      r_ovf       <= 1'b0;
      r_rv        <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_last_b    <= w_last_b_nxt;
      r_alu_a     <= w_alu_a_nxt;
      r_alu_b     <= w_alu_b_nxt;
      r_disp_hold <= w_disp_hold_nxt;
      r_sel       <= w_sel_nxt;
      r_pend_sel  <= w_pend_sel_nxt;
      r_alu_sel   <= w_alu_sel_nxt;
      r_chain     <= w_chain_nxt;
      r_b_ent     <= w_b_ent_nxt;
      r_ovf       <= w_ovf_nxt;
      r_rv        <= w_rv_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_last_b_nxt    = r_last_b;
    w_alu_a_nxt     = r_alu_a;
    w_alu_b_nxt     = r_alu_b;
    w_disp_hold_nxt = r_disp_hold;
    w_sel_nxt       = r_sel;
    w_pend_sel_nxt  = r_pend_sel;
    w_alu_sel_nxt   = r_alu_sel;
    w_chain_nxt     = r_chain;
    w_b_ent_nxt     = r_b_ent;
    w_ovf_nxt       = r_ovf;
    w_rv_nxt        = 1'b0;
    w_cnt_nxt       = r_cnt;
    w_enter_exec    = 1'b0;
    w_exec_b        = r_b;

    // w_accept is never true in S_EXEC, so clear cannot interrupt a calculation.
    if (w_accept && w_is_clr) begin
      w_a_nxt      = '0;
      w_b_nxt      = '0;
      w_last_b_nxt = '0;
      w_sel_nxt    = '0;
      w_ovf_nxt    = 1'b0;
      w_b_ent_nxt  = 1'b0;
      w_chain_nxt  = 1'b0;
      w_state_nxt  = S_A;
    end else begin
      case (r_state)
        S_A: begin
          if (w_accept && w_is_digit) begin
            if (w_acc_ovf) w_ovf_nxt = 1'b1;
            else           w_a_nxt   = w_acc_sum;
          end else if (w_accept && w_is_op) begin
            w_sel_nxt   = bus.key_code[2:0];
            w_b_nxt     = '0;
            w_b_ent_nxt = 1'b0;
            w_state_nxt = S_B;
          end
        end
        S_B: begin
          if (w_accept && w_is_digit) begin
            if (w_acc_ovf) begin
              w_ovf_nxt = 1'b1;
            end else begin
              w_b_nxt     = w_acc_sum;
              w_b_ent_nxt = 1'b1;
            end
          end else if (w_accept && w_is_op) begin
            if (!r_b_ent) begin
              w_sel_nxt = bus.key_code[2:0];
            end else begin
              w_pend_sel_nxt = bus.key_code[2:0];
              w_chain_nxt    = 1'b1;
              w_enter_exec   = 1'b1;
            end
          end else if (w_accept && w_is_eq && r_b_ent) begin
            w_chain_nxt  = 1'b0;
            w_enter_exec = 1'b1;
          end
        end
        S_EXEC: begin
          if (r_cnt == CNT_W'(ALU_WAIT - 1)) begin
            w_rv_nxt = 1'b1;
            w_a_nxt  = bus.alu_y;
            if (r_chain) begin
              w_sel_nxt   = r_pend_sel;
              w_b_nxt     = '0;
              w_b_ent_nxt = 1'b0;
              w_state_nxt = S_B;
            end else begin
              // r_alu_b is B for both a fresh equals and a repeat-equals.
              w_last_b_nxt = r_alu_b;
              w_state_nxt  = S_SHOW;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_SHOW: begin
          if (w_accept && w_is_digit) begin
            w_a_nxt     = WIDTH'(w_digit);
            w_state_nxt = S_A;
          end else if (w_accept && w_is_op) begin
            w_sel_nxt   = bus.key_code[2:0];
            w_b_nxt     = '0;
            w_b_ent_nxt = 1'b0;
            w_state_nxt = S_B;
          end else if (w_accept && w_is_eq) begin
            w_b_nxt      = r_last_b;
            w_exec_b     = r_last_b;
            w_chain_nxt  = 1'b0;
            w_enter_exec = 1'b1;
          end
        end
        default: w_state_nxt = S_A;
      endcase
    end

    // ALU inputs change only here, so they stay constant for the whole
    // S_EXEC window and hold their values afterwards.
    if (w_enter_exec) begin
      w_state_nxt     = S_EXEC;
      w_cnt_nxt       = '0;
      w_alu_a_nxt     = r_a;
      w_alu_b_nxt     = w_exec_b;
      w_alu_sel_nxt   = r_sel;
      w_disp_hold_nxt = w_display;
    end
  end

  assign bus.key_ready    = w_key_ready;
  assign bus.alu_a        = r_alu_a;
  assign bus.alu_b        = r_alu_b;
  assign bus.alu_sel      = r_alu_sel;
  assign bus.display      = w_display;
  assign bus.result_valid = r_rv;
  assign bus.entry_ovf    = r_ovf;
endmodule

// File: tb/tb_calc_key_sequencer.sv
// -----------------------------------------------------------------------------
// tb_calc_key_sequencer
// Directed bench for calc_key_sequencer. Two instances share clock and reset:
// u1 with ALU_WAIT=1 and u3 with ALU_WAIT=3. Each has a bench ALU (add for
// Sel 000, sub for 001, AND otherwise).
// -----------------------------------------------------------------------------
module tb_calc_key_sequencer;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  calc_key_sequencer_if #(.WIDTH(8)) b1 ();
  calc_key_sequencer_if #(.WIDTH(8)) b3 ();

  calc_key_sequencer #(.WIDTH(8), .ALU_WAIT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  calc_key_sequencer #(.WIDTH(8), .ALU_WAIT(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] s);
    case (s)
      3'b000:  return a + b;
      3'b001:  return a - b;
      default: return a & b;
    endcase
  endfunction

  assign b1.alu_y = ref_alu(b1.alu_a, b1.alu_b, b1.alu_sel);
  assign b3.alu_y = ref_alu(b3.alu_a, b3.alu_b, b3.alu_sel);

  // Presents a key, waits (bounded) for key_ready, and releases it just after
  // the accepting edge.
  task automatic send_key(input int inst, input logic [4:0] k);
    int n;
    logic rdy;
    n = 0;
    @(negedge clk);
    if (inst == 1) begin b1.key_valid = 1'b1; b1.key_code = k; end
    else           begin b3.key_valid = 1'b1; b3.key_code = k; end
    rdy = (inst == 1) ? b1.key_ready : b3.key_ready;
    while (rdy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
      rdy = (inst == 1) ? b1.key_ready : b3.key_ready;
    end
    total++;
    if (rdy !== 1'b1) begin
      bad++;
      $display("FAIL key_accept inst=%0d key=%h: key_ready=%b required 1", inst, k, rdy);
    end
    @(posedge clk);
    #1;
    if (inst == 1) b1.key_valid = 1'b0;
    else           b3.key_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b1.key_valid = 1'b0; b1.key_code = 5'h00;
    b3.key_valid = 1'b0; b3.key_code = 5'h00;
    repeat (3) @(negedge clk);
    total++;
    if ({b1.key_ready, b1.result_valid, b1.entry_ovf, b1.alu_sel} !== 6'b100_000) begin
      bad++;
      $display("FAIL reset_ctl_u1: got %b required 100000",
               {b1.key_ready, b1.result_valid, b1.entry_ovf, b1.alu_sel});
    end
    total++;
    if ({b1.alu_a, b1.alu_b, b1.display} !== 24'h0) begin
      bad++;
      $display("FAIL reset_data_u1: got %h required 000000", {b1.alu_a, b1.alu_b, b1.display});
    end
    total++;
    if ({b3.key_ready, b3.result_valid, b3.entry_ovf, b3.alu_a, b3.display} !== {3'b100, 16'h0}) begin
      bad++;
      $display("FAIL reset_u3: got %h required %h",
               {b3.key_ready, b3.result_valid, b3.entry_ovf, b3.alu_a, b3.display}, {3'b100, 16'h0});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_add();
    send_key(1, 5'h01);
    send_key(1, 5'h02);
    @(negedge clk);
    total++;
    if (b1.display !== 8'd12) begin
      bad++; $display("FAIL add_entry_a: display=%0d required 12", b1.display);
    end
    send_key(1, 5'h10);
    send_key(1, 5'h03);
    send_key(1, 5'h00);
    @(negedge clk);
    total++;
    if (b1.display !== 8'd30) begin
      bad++; $display("FAIL add_entry_b: display=%0d required 30", b1.display);
    end
    send_key(1, KEY_EQ);
    @(negedge clk);
    total++;
    if ({b1.alu_a, b1.alu_b, b1.alu_sel} !== {8'd12, 8'd30, SEL_ADD}) begin
      bad++;
      $display("FAIL add_alu_drive: a=%0d b=%0d sel=%b required 12 30 000",
               b1.alu_a, b1.alu_b, b1.alu_sel);
    end
    total++;
    if ({b1.key_ready, b1.result_valid, b1.display} !== {2'b00, 8'd30}) begin
      bad++;
      $display("FAIL add_exec_ctl: ready=%b rv=%b display=%0d required 0 0 30",
               b1.key_ready, b1.result_valid, b1.display);
    end
    @(negedge clk);
    total++;
    if ({b1.result_valid, b1.display} !== {1'b1, 8'd42}) begin
      bad++;
      $display("FAIL add_result: rv=%b display=%0d required 1 42", b1.result_valid, b1.display);
    end
    @(negedge clk);
    total++;
    if ({b1.result_valid, b1.display, b1.key_ready} !== {1'b0, 8'd42, 1'b1}) begin
      bad++;
      $display("FAIL add_after: rv=%b display=%0d ready=%b required 0 42 1",
               b1.result_valid, b1.display, b1.key_ready);
    end
  endtask

  task automatic test_entry_ovf();
    send_key(1, KEY_CLR);
    send_key(1, 5'h02);
    send_key(1, 5'h05);
    send_key(1, 5'h06);
    @(negedge clk);
    total++;
    if ({b1.display, b1.entry_ovf} !== {8'd25, 1'b1}) begin
      bad++;
      $display("FAIL ovf_set: display=%0d ovf=%b required 25 1", b1.display, b1.entry_ovf);
    end
    send_key(1, KEY_CLR);
    @(negedge clk);
    total++;
    if ({b1.display, b1.entry_ovf} !== {8'd0, 1'b0}) begin
      bad++;
      $display("FAIL ovf_clear: display=%0d ovf=%b required 0 0", b1.display, b1.entry_ovf);
    end
  endtask

  task automatic test_chain_repeat();
    send_key(1, 5'h05);
    send_key(1, 5'h10);
    send_key(1, 5'h03);
    send_key(1, 5'h11);
    @(negedge clk);
    total++;
    if ({b1.alu_a, b1.alu_b, b1.alu_sel} !== {8'd5, 8'd3, SEL_ADD}) begin
      bad++;
      $display("FAIL chain_alu_drive: a=%0d b=%0d sel=%b required 5 3 000",
               b1.alu_a, b1.alu_b, b1.alu_sel);
    end
    @(negedge clk);
    total++;
    if ({b1.result_valid, b1.display} !== {1'b1, 8'd8}) begin
      bad++;
      $display("FAIL chain_result: rv=%b display=%0d required 1 8", b1.result_valid, b1.display);
    end
    total++;
    if (u1.r_state !== S_B || u1.r_sel !== SEL_SUB) begin
      bad++;
      $display("FAIL chain_state: state=%0d sel=%b required 1 001", u1.r_state, u1.r_sel);
    end
    send_key(1, 5'h02);
    @(negedge clk);
    total++;
    if (b1.display !== 8'd2) begin
      bad++; $display("FAIL chain_entry_b: display=%0d required 2", b1.display);
    end
    send_key(1, KEY_EQ);
    @(negedge clk);
    total++;
    if ({b1.alu_a, b1.alu_b, b1.alu_sel} !== {8'd8, 8'd2, SEL_SUB}) begin
      bad++;
      $display("FAIL chain_eq_drive: a=%0d b=%0d sel=%b required 8 2 001",
               b1.alu_a, b1.alu_b, b1.alu_sel);
    end
    @(negedge clk);
    total++;
    if ({b1.result_valid, b1.display} !== {1'b1, 8'd6}) begin
      bad++;
      $display("FAIL chain_eq_result: rv=%b display=%0d required 1 6", b1.result_valid, b1.display);
    end
    send_key(1, KEY_EQ);
    @(negedge clk);
    total++;
    if ({b1.alu_a, b1.alu_b, b1.alu_sel} !== {8'd6, 8'd2, SEL_SUB}) begin
      bad++;
      $display("FAIL repeat1_drive: a=%0d b=%0d sel=%b required 6 2 001",
               b1.alu_a, b1.alu_b, b1.alu_sel);
    end
    @(negedge clk);
    total++;
    if ({b1.result_valid, b1.display} !== {1'b1, 8'd4}) begin
      bad++;
      $display("FAIL repeat1_result: rv=%b display=%0d required 1 4", b1.result_valid, b1.display);
    end
    send_key(1, KEY_EQ);
    repeat (2) @(negedge clk);
    total++;
    if ({b1.result_valid, b1.display} !== {1'b1, 8'd2}) begin
      bad++;
      $display("FAIL repeat2_result: rv=%b display=%0d required 1 2", b1.result_valid, b1.display);
    end
  endtask

  task automatic test_op_replace_wrap();
    send_key(1, KEY_CLR);
    send_key(1, 5'h09);
    send_key(1, KEY_EQ);
    send_key(1, 5'h0A);
    send_key(1, 5'h1F);
    @(negedge clk);
    total++;
    if (b1.display !== 8'd9 || u1.r_state !== S_A) begin
      bad++;
      $display("FAIL ignored_keys: display=%0d state=%0d required 9 0", b1.display, u1.r_state);
    end
    send_key(1, 5'h10);
    send_key(1, 5'h11);
    @(negedge clk);
    total++;
    if (u1.r_sel !== SEL_SUB || b1.display !== 8'd9) begin
      bad++;
      $display("FAIL op_replace: sel=%b display=%0d required 001 9", u1.r_sel, b1.display);
    end
    send_key(1, 5'h01);
    send_key(1, 5'h00);
    send_key(1, KEY_EQ);
    @(negedge clk);
    total++;
    if (b1.alu_sel !== SEL_SUB) begin
      bad++; $display("FAIL wrap_drive: sel=%b required 001", b1.alu_sel);
    end
    @(negedge clk);
    total++;
    if ({b1.result_valid, b1.display} !== {1'b1, 8'd255}) begin
      bad++;
      $display("FAIL wrap_result: rv=%b display=%0d required 1 255", b1.result_valid, b1.display);
    end
  endtask

  task automatic test_backpressure();
    send_key(3, 5'h01);
    send_key(3, 5'h10);
    send_key(3, 5'h02);
    send_key(3, KEY_EQ);
    b3.key_valid = 1'b1;
    b3.key_code  = KEY_CLR;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({b3.key_ready, b3.result_valid} !== 2'b00) begin
        bad++;
        $display("FAIL bp_hold_%0d: ready=%b rv=%b required 0 0", i, b3.key_ready, b3.result_valid);
      end
    end
    @(negedge clk);
    total++;
    if ({b3.result_valid, b3.display, b3.key_ready} !== {1'b1, 8'd3, 1'b1}) begin
      bad++;
      $display("FAIL bp_result: rv=%b display=%0d ready=%b required 1 3 1",
               b3.result_valid, b3.display, b3.key_ready);
    end
    @(posedge clk);
    #1;
    b3.key_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({b3.result_valid, b3.display} !== {1'b0, 8'd0}) begin
      bad++;
      $display("FAIL bp_clear: rv=%b display=%0d required 0 0", b3.result_valid, b3.display);
    end
  endtask

  task automatic test_reset_mid_exec();
    send_key(3, 5'h04);
    send_key(3, 5'h10);
    send_key(3, 5'h05);
    send_key(3, KEY_EQ);
    @(negedge clk);
    total++;
    if ({b3.alu_a, b3.key_ready} !== {8'd4, 1'b0}) begin
      bad++;
      $display("FAIL rst_pre: alu_a=%0d ready=%b required 4 0", b3.alu_a, b3.key_ready);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({b3.key_ready, b3.result_valid, b3.alu_a, b3.display} !== {2'b10, 16'h0}) begin
      bad++;
      $display("FAIL rst_abort: ready=%b rv=%b alu_a=%0d display=%0d required 1 0 0 0",
               b3.key_ready, b3.result_valid, b3.alu_a, b3.display);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (b3.result_valid !== 1'b0) begin
        bad++; $display("FAIL rst_no_pulse_%0d: rv=%b required 0", i, b3.result_valid);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_entry_ovf();
    test_chain_repeat();
    test_op_replace_wrap();
    test_backpressure();
    test_reset_mid_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/calc_key_sequencer.md
Name: calc_key_sequencer

Overview:
Calculator front-end that drives the 8-bit combinational ALU (operands A, B; 3-bit Sel; result y).
- Consumes a keypad key stream (digits, operators, equals, clear) and builds operands A and B as decimal numbers.
- Drives the ALU operand and select inputs, then waits a settle time, captures y, and presents it on the display.
- Supports chained operations and repeat-equals.

Parameters:
WIDTH, 8, operand/result width; must match the ALU.
ALU_WAIT, 1, cycles the ALU inputs are held stable before y is sampled (minimum 1).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
key_valid  input  1  key code present
key_code  input  5  key: 0x00-0x09 digit; 0x10-0x17 operator, Sel = code[2:0]; 0x18 equals; 0x19 clear; all others ignored
key_ready  output  1  key accepted when key_valid && key_ready
alu_a  output  WIDTH  ALU operand A
alu_b  output  WIDTH  ALU operand B
alu_sel  output  3  ALU select
alu_y  input  WIDTH  ALU result
display  output  WIDTH  value to show
result_valid  output  1  one-cycle pulse when a result is captured
entry_ovf  output  1  sticky: a digit was rejected because entry would exceed 2^WIDTH-1

Behaviour:
Reset (async, rst_n=0): all outputs 0, except key_ready, which is 1. Internal state: A=0, B=0, sel=0, last_b=0, b_entered=0, state S_A.

States are S_A (entering A), S_B (entering B), S_EXEC, S_SHOW.

key_ready:
- 0 in S_EXEC, 1 otherwise.
- Keys presented while key_ready=0 are not consumed; the source holds them.

Digit entry:
- next = cur*10 + d, computed at WIDTH+4 bits.
- If next > 2^WIDTH-1: digit dropped, entry_ovf set, cur unchanged.

Transitions and key handling:
- S_A:
  - digit: accumulate into A.
  - operator: sel = code[2:0], B=0, b_entered=0, go to S_B.
  - equals: no effect.
- S_B:
  - digit: accumulate into B, b_entered=1.
  - operator with b_entered=0: replaces sel.
  - operator with b_entered=1: store pending_sel = code[2:0], chain=1, go to S_EXEC.
  - equals with b_entered=1: chain=0, go to S_EXEC.
  - equals with b_entered=0: ignored.
- S_EXEC:
  - alu_a=A, alu_b=B, alu_sel=sel held constant.
  - After ALU_WAIT cycles, register alu_y as R and pulse result_valid; display=R from the same cycle.
  - If key accepted in cycle N, result_valid is high in cycle N+1+ALU_WAIT.
  - Exit with chain=1: A=R, sel=pending_sel, B=0, b_entered=0, go to S_B.
  - Exit with chain=0: A=R, last_b=B, go to S_SHOW.
- S_SHOW:
  - digit: A=digit, go to S_A.
  - operator: A stays R, sel=code[2:0], go to S_B.
  - equals: B=last_b, same sel, chain=0, go to S_EXEC (repeat last operation).

Clear, in any state except S_EXEC: A=B=last_b=0, sel=0, entry_ovf=0, go to S_A.

Display:
- S_A: A.
- S_B: B if b_entered, else A.
- S_EXEC: previous value held until capture.
- S_SHOW: R.

ALU drive outside S_EXEC: alu_a/alu_b/alu_sel hold their last values, with no glitching.

Arithmetic: the block does no arithmetic on results; ALU wrap-around passes through unchanged.

Reset mid-S_EXEC: aborts immediately; no result_valid pulse; everything returns to reset values.

Decomposition:
Shared package calc_pkg holds:
- key code constants: KEY_EQ=5'h18, KEY_CLR=5'h19, KEY_OP_BASE=5'h10;
- state enum;
- ALU select constants shared with the ALU: SEL_ADD=3'b000, SEL_SUB=3'b001, and the rest of the map.

One sub-module: calc_digit_acc (combinational acc*10+d with overflow flag), instantiated once and muxed onto A or B.

Test Plan:
- Bench ALU: add for Sel 000, sub for 001.
- Basic add: keys 1,2,0x10,3,0,=, ALU_WAIT=1 → in S_EXEC alu_a=12, alu_b=30, alu_sel=000; result_valid one cycle, two cycles after "=" is accepted; display=42.
- Entry overflow: 2,5,6 → display=25, entry_ovf=1; clear → entry_ovf=0, display=0.
- Chain and repeat: 5,0x10,3,0x11 → display=8, state S_B, sel=001; then 2,= → display=6; = again → display=4; = again → 2.
- Operator replace and wrap: 9,0x10,0x11,1,0,= → sel=001, display=255 (9-10 mod 256).
- Backpressure: with ALU_WAIT=3, hold KEY_CLR valid during S_EXEC → key_ready=0 for 3 cycles, result captured, then clear consumed → display=0.
- Reset mid-S_EXEC: drop rst_n during ALU_WAIT → no result_valid; display=0, alu_a=0, key_ready=1 immediately.
